// File: rtl/string_led_sequencer_pkg.sv
// rtl/string_led_sequencer_pkg.sv - shared types and NRZ bit timing for the LED sequencer
package string_led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    LATCH
  } state_t;

  localparam int BIT_TICKS = 3;
  localparam int T0H_TICKS = 1;
  localparam int T1H_TICKS = 2;

  // Active (high before polarity) level of a data bit in the given tick phase.
  function automatic logic bit_active(input logic bit_val, input logic [1:0] phase);
    return bit_val ? (phase < 2'(T1H_TICKS)) : (phase < 2'(T0H_TICKS));
  endfunction

endpackage

// File: rtl/string_led_sequencer_if.sv
// rtl/string_led_sequencer_if.sv - read-only SRAM port 1 used by the LED sequencer
interface string_led_sequencer_if #(
  parameter int ASIZE = 32
);
  logic             cs_n;
  logic [ASIZE-1:0] addr;
  logic [7:0]       rdata;

  modport master (output cs_n, output addr, input rdata);
  modport slave  (input cs_n, input addr, output rdata);
endinterface

// File: rtl/string_led_sequencer_prescaler.sv
// rtl/string_led_sequencer_prescaler.sv - tick generator, one tick every prescaler+1 clk
module string_led_prescaler #(
  parameter int PSIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [PSIZE-1:0] i_prescaler,
  output logic             o_tick
);

  logic [PSIZE-1:0] r_count;

  // >= keeps the counter bounded if prescaler shrinks below the running count
  assign o_tick = (r_count >= i_prescaler);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + PSIZE'(1);
    end
  end

endmodule

// File: rtl/string_led_sequencer.sv
// rtl/string_led_sequencer.sv - streams an SRAM byte window to a WS2812-style serial LED pin
module string_led_sequencer
  import string_led_pkg::*;
#(
  parameter int ASIZE       = 32,
  parameter int PSIZE       = 32,
  parameter int RESET_TICKS = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_controller_en,
  input  logic [PSIZE-1:0]       i_prescaler,
  input  logic                   i_polarity,
  input  logic [3:0]             i_w_count,
  input  logic [ASIZE-1:0]       i_w_first,
  input  logic [ASIZE-1:0]       i_w_last,
  input  logic                   i_start,
  output logic                   o_progress,
  output logic                   o_led,
  string_led_sequencer_if.master sram
);

  localparam int LW = $clog2(RESET_TICKS + 1);

  state_t           r_state;
  logic             r_progress;
  logic             r_cs_n;
  logic             r_led_act;
  logic             r_rd_s1;
  logic             r_have_next;
  logic [ASIZE-1:0] r_addr;
  logic [ASIZE-1:0] r_first;
  logic [ASIZE-1:0] r_last;
  logic [3:0]       r_passes;
  logic [7:0]       r_shift;
  logic [7:0]       r_next;
  logic [2:0]       r_bit_idx;
  logic [1:0]       r_phase;
  logic [LW-1:0]    r_latch_cnt;

  logic w_accept;
  logic w_clr;
  logic w_tick;
  logic w_cur_bit;
  logic w_wrap;

  assign w_accept  = i_start && i_controller_en && (r_state == IDLE) && (i_w_count != 4'd0);
  // Re-align ticks to the first bit so every bit spans a whole number of ticks
  assign w_clr     = w_accept || (r_state == LOAD);
  assign w_cur_bit = r_shift[r_bit_idx];
  assign w_wrap    = (r_addr == r_last) || (r_last < r_first);

  string_led_prescaler #(.PSIZE(PSIZE)) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_prescaler(i_prescaler),
    .o_tick     (w_tick)
  );

  assign o_progress = r_progress;
  assign sram.cs_n  = r_cs_n;
  assign sram.addr  = r_addr;
  // Polarity is static configuration, applied after the active-level register
  assign o_led      = r_led_act ^ i_polarity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_progress  <= 1'b0;
      r_cs_n      <= 1'b1;
      r_led_act   <= 1'b0;
      r_rd_s1     <= 1'b0;
      r_have_next <= 1'b0;
      r_addr      <= '0;
      r_first     <= '0;
      r_last      <= '0;
      r_passes    <= '0;
      r_shift     <= '0;
      r_next      <= '0;
      r_bit_idx   <= '0;
      r_phase     <= '0;
      r_latch_cnt <= '0;
    end else begin
      r_cs_n  <= 1'b1;
      r_rd_s1 <= !r_cs_n;
      if (r_rd_s1) r_next <= sram.rdata;

      if (!i_controller_en) begin
        r_state    <= IDLE;
        r_progress <= 1'b0;
        r_led_act  <= 1'b0;
        r_rd_s1    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_led_act <= 1'b0;
            if (w_accept) begin
              r_state    <= FETCH;
              r_progress <= 1'b1;
              r_cs_n     <= 1'b0;
              r_addr     <= i_w_first;
              r_first    <= i_w_first;
              r_last     <= i_w_last;
              r_passes   <= i_w_count;
            end
          end
          FETCH: r_state <= LOAD;
          LOAD: begin
            r_shift   <= sram.rdata;
            r_bit_idx <= 3'd7;
            r_phase   <= 2'd0;
            r_led_act <= 1'b1;
            r_state   <= SHIFT;
          end
          SHIFT: begin
            if (w_tick) begin
              if (r_phase != 2'(BIT_TICKS - 1)) begin
                r_phase   <= r_phase + 2'd1;
                r_led_act <= bit_active(w_cur_bit, r_phase + 2'd1);
              end else begin
                r_phase <= 2'd0;
                if (r_bit_idx != 3'd0) begin
                  r_bit_idx <= r_bit_idx - 3'd1;
                  r_led_act <= 1'b1;
                  // Bit 0 is starting: prefetch the next byte so it is ready when this one ends
                  if (r_bit_idx == 3'd1) begin
                    if (w_wrap && (r_passes == 4'd1)) begin
                      r_have_next <= 1'b0;
                    end else begin
                      r_have_next <= 1'b1;
                      r_cs_n      <= 1'b0;
                      if (w_wrap) begin
                        r_addr   <= r_first;
                        r_passes <= r_passes - 4'd1;
                      end else begin
                        r_addr <= r_addr + ASIZE'(1);
                      end
                    end
                  end
                end else if (r_have_next) begin
                  r_shift   <= r_next;
                  r_bit_idx <= 3'd7;
                  r_led_act <= 1'b1;
                end else begin
                  r_state     <= LATCH;
                  r_led_act   <= 1'b0;
                  r_latch_cnt <= '0;
                end
              end
            end
          end
          LATCH: begin
            r_led_act <= 1'b0;
            if (w_tick) begin
              if (r_latch_cnt == LW'(RESET_TICKS - 1)) begin
                r_state    <= IDLE;
                r_progress <= 1'b0;
              end else begin
                r_latch_cnt <= r_latch_cnt + LW'(1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_string_led_sequencer.sv
// tb/tb_string_led_sequencer.sv - directed self-checking bench for string_led_sequencer
module tb_string_led_sequencer;

  localparam int ASIZE = 32;
  localparam int PSIZE = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_controller_en;
  logic             i_polarity;
  logic             i_start;
  logic [PSIZE-1:0] i_prescaler;
  logic [3:0]       i_w_count;
  logic [ASIZE-1:0] i_w_first;
  logic [ASIZE-1:0] i_w_last;
  logic             o_progress;
  logic             o_led;

  logic [7:0]  mem [0:255];
  logic [31:0] reads[$];
  logic        mon_en = 1'b0;
  logic        prev_low = 1'b0;
  int          dbl_low = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  string_led_sequencer_if #(.ASIZE(ASIZE)) sif ();

  string_led_sequencer #(.ASIZE(ASIZE), .PSIZE(PSIZE), .RESET_TICKS(128)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_controller_en(i_controller_en),
    .i_prescaler    (i_prescaler),
    .i_polarity     (i_polarity),
    .i_w_count      (i_w_count),
    .i_w_first      (i_w_first),
    .i_w_last       (i_w_last),
    .i_start        (i_start),
    .o_progress     (o_progress),
    .o_led          (o_led),
    .sram           (sif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sif.cs_n === 1'b0) sif.rdata <= mem[sif.addr[7:0]];
  end

  always @(negedge clk) begin
    if (mon_en && sif.cs_n === 1'b0) begin
      if (prev_low) dbl_low++;
      reads.push_back(sif.addr);
    end
    prev_low = (sif.cs_n === 1'b0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cfg(input logic [31:0] p, input logic pol, input logic [3:0] cnt,
                     input logic [31:0] f, input logic [31:0] l);
    i_prescaler = p; i_polarity = pol; i_w_count = cnt; i_w_first = f; i_w_last = l;
  endtask

  task automatic start_pulse();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (o_progress === 1'b0) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    i_controller_en = 1'b1; i_start = 1'b0; cfg(0, 1'b0, 4'd0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_progress, sif.cs_n, o_led} !== 3'b010) begin
      n_bad++; $display("FAIL reset_outputs: got %b required 010", {o_progress, sif.cs_n, o_led});
    end
    n_cmp++;
    if (sif.addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %0d required 0", sif.addr); end
    i_polarity = 1'b1; #1;
    n_cmp++;
    if (o_led !== 1'b1) begin n_bad++; $display("FAIL reset_led_pol: got %b required 1", o_led); end
    i_polarity = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({o_progress, sif.cs_n} !== 2'b01) begin
      n_bad++; $display("FAIL idle_after_reset: got %b required 01", {o_progress, sif.cs_n});
    end
  endtask

  task automatic test_single_byte();
    logic [23:0] got;
    int bad;
    mem[0] = 8'hA5; cfg(0, 1'b0, 4'd1, 0, 0);
    start_pulse();
    n_cmp++;
    if ({o_progress, sif.cs_n} !== 2'b10 || sif.addr !== 32'd0) begin
      n_bad++; $display("FAIL start_outputs: got prog/cs_n %b addr %0d required 10 addr 0", {o_progress, sif.cs_n}, sif.addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({o_progress, sif.cs_n} !== 2'b11) begin
      n_bad++; $display("FAIL fetch_one_clk: got prog/cs_n %b required 11", {o_progress, sif.cs_n});
    end
    for (int i = 0; i < 24; i++) begin @(negedge clk); got[23-i] = o_led; end
    n_cmp++;
    if (got !== 24'b110100110100100110100110) begin
      n_bad++; $display("FAIL a5_waveform: got %b required 110100110100100110100110", got);
    end
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (o_led !== 1'b0 || o_progress !== 1'b1 || sif.cs_n !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL latch_gap: got %0d bad clk required 0", bad); end
    @(negedge clk);
    n_cmp++;
    if ({o_progress, o_led} !== 2'b00) begin
      n_bad++; $display("FAIL progress_fall: got prog/led %b required 00", {o_progress, o_led});
    end
  endtask

  task automatic test_multi_pass();
    logic [7:0]  seq [6];
    logic [31:0] exp_a [6];
    logic [31:0] ga;
    logic        b, e;
    int          bad, first_bad, cyc;
    seq   = '{8'h3C, 8'hC3, 8'h5A, 8'h3C, 8'hC3, 8'h5A};
    exp_a = '{32'd4, 32'd5, 32'd6, 32'd4, 32'd5, 32'd6};
    mem[4] = 8'h3C; mem[5] = 8'hC3; mem[6] = 8'h5A;
    cfg(3, 1'b0, 4'd2, 4, 6);
    reads.delete(); dbl_low = 0; mon_en = 1'b1;
    start_pulse();
    @(negedge clk);
    bad = 0; first_bad = -1;
    for (int k = 0; k < 48; k++) begin
      b = seq[k/8][7-(k%8)];
      for (int j = 0; j < 12; j++) begin
        @(negedge clk);
        e = b ? (j < 8) : (j < 4);
        if (o_led !== e) begin bad++; if (first_bad < 0) first_bad = k * 12 + j; end
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL multi_nrz: got %0d bad clk (first at %0d) required 0", bad, first_bad);
    end
    wait_idle(1000, cyc);
    mon_en = 1'b0;
    n_cmp++;
    if (cyc != 513) begin n_bad++; $display("FAIL multi_latch_len: got %0d required 513", cyc); end
    n_cmp++;
    if (reads.size() != 6) begin n_bad++; $display("FAIL multi_read_count: got %0d required 6", reads.size()); end
    for (int i = 0; i < 6; i++) begin
      ga = (i < reads.size()) ? reads[i] : 32'hFFFF_FFFF;
      n_cmp++;
      if (ga !== exp_a[i]) begin n_bad++; $display("FAIL multi_addr[%0d]: got %0d required %0d", i, ga, exp_a[i]); end
    end
    n_cmp++;
    if (dbl_low != 0) begin n_bad++; $display("FAIL cs_n_double_low: got %0d required 0", dbl_low); end
  endtask

  task automatic test_polarity();
    logic [23:0] got;
    int cyc;
    mem[0] = 8'hFF; cfg(0, 1'b1, 4'd1, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (o_led !== 1'b1) begin n_bad++; $display("FAIL pol_idle: got %b required 1", o_led); end
    start_pulse();
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin @(negedge clk); got[23-i] = o_led; end
    n_cmp++;
    if (got !== {8{3'b001}}) begin n_bad++; $display("FAIL pol_waveform: got %b required %b", got, {8{3'b001}}); end
    wait_idle(200, cyc);
    n_cmp++;
    if (cyc != 129 || o_led !== 1'b1) begin
      n_bad++; $display("FAIL pol_latch_end: got cyc %0d led %b required 129 led 1", cyc, o_led);
    end
  endtask

  task automatic test_abort();
    logic [23:0] got;
    int cyc;
    mem[1] = 8'hFF; cfg(0, 1'b1, 4'd3, 1, 1);
    start_pulse();
    @(negedge clk);
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({o_progress, o_led} !== 2'b10) begin
      n_bad++; $display("FAIL pre_abort: got prog/led %b required 10", {o_progress, o_led});
    end
    i_controller_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_progress, o_led, sif.cs_n} !== 3'b011) begin
      n_bad++; $display("FAIL abort_outputs: got prog/led/cs_n %b required 011", {o_progress, o_led, sif.cs_n});
    end
    i_controller_en = 1'b1;
    mem[0] = 8'hA5; cfg(0, 1'b0, 4'd1, 0, 0);
    start_pulse();
    n_cmp++;
    if ({o_progress, sif.cs_n} !== 2'b10 || sif.addr !== 32'd0) begin
      n_bad++; $display("FAIL restart_outputs: got prog/cs_n %b addr %0d required 10 addr 0", {o_progress, sif.cs_n}, sif.addr);
    end
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin @(negedge clk); got[23-i] = o_led; end
    n_cmp++;
    if (got !== 24'b110100110100100110100110) begin
      n_bad++; $display("FAIL restart_waveform: got %b required 110100110100100110100110", got);
    end
    wait_idle(200, cyc);
    n_cmp++;
    if (cyc != 129) begin n_bad++; $display("FAIL restart_latch_len: got %0d required 129", cyc); end
  endtask

  task automatic test_ignored_starts();
    int bad, cyc;
    logic [31:0] ga;
    cfg(0, 1'b0, 4'd0, 0, 0);
    start_pulse();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_progress !== 1'b0 || sif.cs_n !== 1'b1) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL zero_count_start: got %0d active clk required 0", bad); end
    cfg(0, 1'b0, 4'd1, 4, 6);
    reads.delete(); mon_en = 1'b1;
    start_pulse();
    cyc = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 5) i_start = 1'b1;
      if (i == 6) i_start = 1'b0;
      if (o_progress === 1'b0) begin cyc = i; break; end
    end
    mon_en = 1'b0;
    n_cmp++;
    if (cyc != 202) begin n_bad++; $display("FAIL busy_start_len: got %0d required 202", cyc); end
    n_cmp++;
    if (reads.size() != 3) begin n_bad++; $display("FAIL busy_start_reads: got %0d required 3", reads.size()); end
    ga = (reads.size() > 2) ? reads[2] : 32'hFFFF_FFFF;
    n_cmp++;
    if (ga !== 32'd6) begin n_bad++; $display("FAIL busy_start_last_addr: got %0d required 6", ga); end
  endtask

  task automatic test_inverted_window();
    int cyc;
    logic [31:0] g0, g1;
    mem[9] = 8'h81; cfg(0, 1'b0, 4'd2, 9, 3);
    reads.delete(); mon_en = 1'b1;
    start_pulse();
    wait_idle(400, cyc);
    mon_en = 1'b0;
    n_cmp++;
    if (cyc != 178) begin n_bad++; $display("FAIL inv_window_len: got %0d required 178", cyc); end
    g0 = (reads.size() > 0) ? reads[0] : 32'hFFFF_FFFF;
    g1 = (reads.size() > 1) ? reads[1] : 32'hFFFF_FFFF;
    n_cmp++;
    if (reads.size() != 2 || g0 !== 32'd9 || g1 !== 32'd9) begin
      n_bad++; $display("FAIL inv_window_reads: got n=%0d %0d,%0d required n=2 9,9", reads.size(), g0, g1);
    end
    cfg(0, 1'b1, 4'd1, 9, 9);
    start_pulse();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({o_progress, o_led} !== 2'b10) begin
      n_bad++; $display("FAIL pre_reset_shift: got prog/led %b required 10", {o_progress, o_led});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_progress, sif.cs_n, o_led} !== 3'b011 || sif.addr !== 32'd0) begin
      n_bad++; $display("FAIL async_reset: got prog/cs_n/led %b addr %0d required 011 addr 0", {o_progress, sif.cs_n, o_led}, sif.addr);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({o_progress, sif.cs_n} !== 2'b01) begin
      n_bad++; $display("FAIL post_reset_idle: got %b required 01", {o_progress, sif.cs_n});
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_multi_pass();
    test_polarity();
    test_abort();
    test_ignored_starts();
    test_inverted_window();
    n_cmp++;
    if (dbl_low != 0) begin n_bad++; $display("FAIL cs_n_never_double: got %0d required 0", dbl_low); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
